vga_pattern_tx: RTL and testbench

//  VGA-style source: generates 640x480@60 HSOUT/VSOUT/DE timing and 24-bit RGB on the pixel clock.

---
 rtl/vga_timing_pkg.sv | 54 +++++
 rtl/vga_pattern_tx_if.sv | 12 +
 rtl/vga_timing_counter.sv | 63 ++++++
 rtl/vga_pattern_tx.sv | 117 +++++++++++
 tb/tb_vga_pattern_tx.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// vga_pattern_tx shared definitions: 640x480@60 timing,
// pattern codes, underflow colour and the pattern generator.
package vga_timing_pkg;

  localparam int WIDTH   = 640;
  localparam int FRONT_H = 16;
  localparam int PULSE_H = 96;
  localparam int BACK_H  = 48;
  localparam int HEIGHT  = 480;
  localparam int FRONT_V = 10;
  localparam int PULSE_V = 2;
  localparam int BACK_V  = 33;
  localparam bit SYNC_POL = 1'b1;

  localparam int HT = PULSE_H + BACK_H + WIDTH + FRONT_H;
  localparam int VT = PULSE_V + BACK_V + HEIGHT + FRONT_V;

  localparam int CW = 11;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    PAT_STREAM = 2'd0,
    PAT_BARS   = 2'd1,
    PAT_CHECK  = 2'd2,
    PAT_RAMP   = 2'd3
  } pat_e;

  localparam rgb_t UNDERFLOW_RGB = 24'hFF00FF;

  // Bar index bits map straight onto the colour:
  // R off for bars 2,3,6,7, G off for 4..7, B off for odd bars.
  function automatic rgb_t pattern_rgb(
    input pat_e          p,
    input logic [CW-1:0] x,
    input logic [CW-1:0] y,
    input int            bar_w
  );
    rgb_t       c;
    logic [2:0] idx;
    c   = '0;
    idx = '0;
    for (int i = 1; i < 8; i++)
      if (int'(x) >= i * bar_w) idx = 3'(i);
    case (p)
      PAT_BARS:  c = {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
      PAT_CHECK: c = (x[3] ^ y[3]) ? 24'hFFFFFF : 24'h000000;
      PAT_RAMP:  c = {x[7:0], y[7:0], x[7:0] ^ y[7:0]};
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pattern_tx_if.sv
// vga_pattern_tx pixel stream bundle.
// master = frame-buffer reader, slave = pattern transmitter.
interface vga_pattern_tx_if;
  import vga_timing_pkg::*;

  rgb_t pix_data;
  logic pix_valid;
  logic pix_ready;

  modport master (output pix_data, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/vga_timing_counter.sv
// vga_timing_counter: raster h/v counters and the
// sync/active/origin flags decoded from them.
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int Width  = WIDTH,
  parameter int FrontH = FRONT_H,
  parameter int PulseH = PULSE_H,
  parameter int BackH  = BACK_H,
  parameter int Height = HEIGHT,
  parameter int FrontV = FRONT_V,
  parameter int PulseV = PULSE_V,
  parameter int BackV  = BACK_V
) (
  input  logic          VGA_IN_DATA_CLK,
  input  logic          rst,
  input  logic          i_enable,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_act,
  output logic          o_origin,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y
);

  localparam int LHT = PulseH + BackH + Width + FrontH;
  localparam int LVT = PulseV + BackV + Height + FrontV;
  localparam int HA  = PulseH + BackH;
  localparam int VA  = PulseV + BackV;

  logic [CW-1:0] r_h;
  logic [CW-1:0] r_v;
  logic          w_h_end;
  logic          w_v_end;
  logic          w_h_act;
  logic          w_v_act;

  assign w_h_end = (r_h == CW'(LHT - 1));
  assign w_v_end = (r_v == CW'(LVT - 1));

  // h steps every clock, v steps on h wrap, both wrap at frame end
  always_ff @(posedge VGA_IN_DATA_CLK) begin
    if (rst || !i_enable) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_end) begin
      r_h <= '0;
      r_v <= w_v_end ? '0 : r_v + CW'(1);
    end else begin
      r_h <= r_h + CW'(1);
    end
  end

  assign w_h_act  = (r_h >= CW'(HA)) && (r_h < CW'(HA + Width));
  assign w_v_act  = (r_v >= CW'(VA)) && (r_v < CW'(VA + Height));
  assign o_hs     = (r_h < CW'(PulseH));
  assign o_vs     = (r_v < CW'(PulseV));
  assign o_act    = w_h_act && w_v_act;
  assign o_origin = (r_h == '0) && (r_v == '0);
  assign o_x      = r_h - CW'(HA);
  assign o_y      = r_v - CW'(VA);

endmodule

// File: rtl/vga_pattern_tx.sv
// vga_pattern_tx: VGA source with stream or test pattern
// pixels, registered sync/DE/RGB and an underflow counter.
module vga_pattern_tx
  import vga_timing_pkg::*;
#(
  parameter int Width   = WIDTH,
  parameter int FrontH  = FRONT_H,
  parameter int PulseH  = PULSE_H,
  parameter int BackH   = BACK_H,
  parameter int Height  = HEIGHT,
  parameter int FrontV  = FRONT_V,
  parameter int PulseV  = PULSE_V,
  parameter int BackV   = BACK_V,
  parameter bit SyncPol = SYNC_POL
) (
  input  logic         VGA_IN_DATA_CLK,
  input  logic         rst,
  input  logic         enable,
  input  logic [1:0]   pattern_sel,
  vga_pattern_tx_if.slave pix,
  output logic         frame_start,
  output logic         hsync,
  output logic         vsync,
  output logic         de,
  output logic [7:0]   red,
  output logic [7:0]   green,
  output logic [7:0]   blue,
  output logic [15:0]  underflow_cnt
);

  logic          w_hs;
  logic          w_vs;
  logic          w_act;
  logic          w_origin;
  logic [CW-1:0] w_x;
  logic [CW-1:0] w_y;
  logic          w_run;
  rgb_t          w_rgb;

  pat_e          r_pat;
  logic [15:0]   r_under;
  logic          r_fs;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_de;
  rgb_t          r_rgb;

  vga_timing_counter #(
    .Width  (Width),
    .FrontH (FrontH),
    .PulseH (PulseH),
    .BackH  (BackH),
    .Height (Height),
    .FrontV (FrontV),
    .PulseV (PulseV),
    .BackV  (BackV)
  ) u_cnt (
    .VGA_IN_DATA_CLK (VGA_IN_DATA_CLK),
    .rst             (rst),
    .i_enable        (enable),
    .o_hs            (w_hs),
    .o_vs            (w_vs),
    .o_act           (w_act),
    .o_origin        (w_origin),
    .o_x             (w_x),
    .o_y             (w_y)
  );

  assign w_run = enable & ~rst;

  assign pix.pix_ready = w_act & w_run & (r_pat == PAT_STREAM);

  // colour for the current slot; a starved stream slot shows magenta
  always_comb begin
    w_rgb = pattern_rgb(r_pat, w_x, w_y, Width / 8);
    if (r_pat == PAT_STREAM)
      w_rgb = pix.pix_valid ? pix.pix_data : UNDERFLOW_RGB;
  end

  // pattern switches only at the frame origin; count starved slots
  always_ff @(posedge VGA_IN_DATA_CLK) begin
    if (rst) begin
      r_pat   <= PAT_STREAM;
      r_under <= '0;
    end else if (enable) begin
      if (w_origin)
        r_pat <= pat_e'(pattern_sel);
      if (pix.pix_ready && !pix.pix_valid && r_under != '1)
        r_under <= r_under + 16'd1;
    end
  end

  // one-cycle registered view of the current counter slot
  always_ff @(posedge VGA_IN_DATA_CLK) begin
    if (!w_run) begin
      r_fs    <= 1'b0;
      r_hsync <= ~SyncPol;
      r_vsync <= ~SyncPol;
      r_de    <= 1'b0;
      r_rgb   <= '0;
    end else begin
      r_fs    <= w_origin;
      r_hsync <= SyncPol ? w_hs : ~w_hs;
      r_vsync <= SyncPol ? w_vs : ~w_vs;
      r_de    <= w_act;
      r_rgb   <= w_act ? w_rgb : '0;
    end
  end

  assign frame_start        = r_fs;
  assign hsync              = r_hsync;
  assign vsync              = r_vsync;
  assign de                 = r_de;
  assign {red, green, blue} = r_rgb;
  assign underflow_cnt      = r_under;

endmodule

// File: tb/tb_vga_pattern_tx.sv
// tb_vga_pattern_tx: reduced-raster bench with an arithmetic
// raster model, a capture monitor and directed pixel tables.
module tb_vga_pattern_tx;

  localparam int W  = 64;
  localparam int FH = 4;
  localparam int PH = 8;
  localparam int BH = 6;
  localparam int H  = 24;
  localparam int FV = 2;
  localparam int PV = 2;
  localparam int BV = 3;
  localparam int HT = PH + BH + W + FH;
  localparam int VT = PV + BV + H + FV;
  localparam int FT = HT * VT;
  localparam int NPIX = W * H;

  logic        VGA_IN_DATA_CLK = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        frame_start, hsync, vsync, de;
  logic [7:0]  red, green, blue;
  logic [15:0] underflow_cnt;

  vga_pattern_tx_if pix ();

  vga_pattern_tx #(
    .Width(W), .FrontH(FH), .PulseH(PH), .BackH(BH),
    .Height(H), .FrontV(FV), .PulseV(PV), .BackV(BV),
    .SyncPol(1'b1)
  ) dut (
    .VGA_IN_DATA_CLK (VGA_IN_DATA_CLK),
    .rst             (rst),
    .enable          (enable),
    .pattern_sel     (pattern_sel),
    .pix             (pix),
    .frame_start     (frame_start),
    .hsync           (hsync),
    .vsync           (vsync),
    .de              (de),
    .red             (red),
    .green           (green),
    .blue            (blue),
    .underflow_cnt   (underflow_cnt)
  );

  always #5 VGA_IN_DATA_CLK = ~VGA_IN_DATA_CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // reference model: linear raster position, latched pattern
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
    24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  int          m_p = 0;
  int          m_pat = 0;
  int          m_under = 0;
  bit          m_ready;
  logic [43:0] m_exp;

  function automatic logic [23:0] ref_rgb(int pat, int x, int y,
                                          bit vl, logic [23:0] d);
    case (pat)
      0: return vl ? d : 24'hFF00FF;
      1: return bars[x / (W / 8)];
      2: return (((x / 8) + (y / 8)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
      default: return {8'(x % 256), 8'(y % 256), 8'((x ^ y) % 256)};
    endcase
  endfunction

  task automatic model_step(bit r, bit e, int s, bit vl,
                            logic [23:0] d);
    int h, v;
    bit act;
    logic [23:0] c;
    m_ready = 0;
    if (r) begin
      m_p = 0; m_pat = 0; m_under = 0;
      m_exp = '0;
    end else if (!e) begin
      m_p = 0;
      m_exp = {4'b0, 24'h0, 16'(m_under)};
    end else begin
      h = m_p % HT;
      v = m_p / HT;
      act = h >= PH + BH && h < PH + BH + W &&
            v >= PV + BV && v < PV + BV + H;
      m_ready = act && m_pat == 0;
      if (m_ready && !vl && m_under < 65535) m_under++;
      c = act ? ref_rgb(m_pat, h - PH - BH, v - PV - BV, vl, d) : 24'h0;
      m_exp = {m_p == 0, h < PH, v < PV, act, c, 16'(m_under)};
      if (m_p == 0) m_pat = s;
      m_p = (m_p + 1) % FT;
    end
  endtask

  // capture monitor state
  int          nframes = 0;
  int          fr_len = 0, fr_hs = 0, fr_vs = 0, fr_de = 0, fr_hsk = 0;
  int          last_len, last_hs, last_vs, last_de, last_hsk;
  logic [23:0] cur [NPIX];
  logic [23:0] last_cap [NPIX];
  logic [23:0] bars_a [NPIX];
  logic [23:0] bars_b [NPIX];
  logic [23:0] chk [NPIX];
  logic [23:0] ramp [NPIX];
  logic [23:0] sdat = 24'd0;
  int          drop_left = 0;

  task automatic step(bit r, bit e, logic [1:0] s, bit vl,
                      logic [23:0] d);
    rst = r; enable = e; pattern_sel = s;
    pix.pix_valid = vl; pix.pix_data = d;
    #1;
    model_step(r, e, int'(s), vl, d);
    check("pix_ready", 64'(pix.pix_ready), 64'(m_ready));
    if (pix.pix_ready && vl) begin fr_hsk++; sdat++; end
    if (drop_left > 0) drop_left--;
    @(posedge VGA_IN_DATA_CLK);
    #1;
    check("outputs", 64'({frame_start, hsync, vsync, de,
                          red, green, blue, underflow_cnt}), 64'(m_exp));
    if (frame_start) begin
      last_len = fr_len; last_hs = fr_hs; last_vs = fr_vs;
      last_de = fr_de; last_hsk = fr_hsk; last_cap = cur;
      fr_len = 0; fr_hs = 0; fr_vs = 0; fr_de = 0; fr_hsk = 0;
      nframes++;
    end
    fr_len++;
    if (hsync) fr_hs++;
    if (vsync) fr_vs++;
    if (de) begin
      if (fr_de < NPIX) cur[fr_de] = {red, green, blue};
      fr_de++;
    end
  endtask

  task automatic sstep(logic [1:0] s);
    step(1'b0, 1'b1, s, drop_left == 0, sdat);
  endtask

  task automatic run_to(int n, logic [1:0] s);
    int guard = 0;
    while (nframes < n && guard < 3 * FT) begin sstep(s); guard++; end
    check("frame_reached", 64'(nframes), 64'(n));
  endtask

  task automatic check_frame(int hsk);
    check("frame_len", 64'(last_len), 64'(FT));
    check("hsync_cycles", 64'(last_hs), 64'(PH * VT));
    check("vsync_cycles", 64'(last_vs), 64'(PV * HT));
    check("de_cycles", 64'(last_de), 64'(NPIX));
    check("handshakes", 64'(last_hsk), 64'(hsk));
  endtask

  typedef struct {
    int          fb;
    int          x;
    int          y;
    logic [23:0] rgb;
  } vec_t;

  vec_t vt [22];

  initial begin
    logic [23:0] got;
    int nmag, nf, guard;
    bit r, e;
    logic [1:0] s;

    vt = '{
      '{0, 0, 0, 24'hFFFFFF}, '{0, 7, 0, 24'hFFFFFF},
      '{0, 8, 0, 24'hFFFF00}, '{0, 16, 0, 24'h00FFFF},
      '{0, 24, 0, 24'h00FF00}, '{0, 32, 0, 24'hFF00FF},
      '{0, 40, 0, 24'hFF0000}, '{0, 48, 0, 24'h0000FF},
      '{0, 63, 0, 24'h000000}, '{0, 56, 5, 24'h000000},
      '{1, 8, 12, 24'hFFFF00}, '{1, 56, 23, 24'h000000},
      '{1, 0, 23, 24'hFFFFFF},
      '{2, 0, 0, 24'h000000}, '{2, 8, 0, 24'hFFFFFF},
      '{2, 8, 8, 24'h000000}, '{2, 0, 8, 24'hFFFFFF},
      '{2, 15, 23, 24'hFFFFFF},
      '{3, 0, 0, 24'h000000}, '{3, 5, 3, 24'h050306},
      '{3, 63, 23, 24'h3F1728}, '{3, 16, 1, 24'h100111}
    };

    @(posedge VGA_IN_DATA_CLK);
    #1;
    step(1'b1, 1'b0, 2'd0, 1'b0, 24'h0);
    step(1'b1, 1'b1, 2'd2, 1'b1, 24'h0);
    check("reset_idle", 64'({frame_start, hsync, vsync, de,
                             red, green, blue, underflow_cnt}), 64'(0));

    run_to(2, 2'd1);
    check_frame(0);
    bars_a = last_cap;

    for (int i = 0; i < FT / 2; i++) sstep(2'd1);
    run_to(3, 2'd2);
    bars_b = last_cap;
    run_to(4, 2'd2);
    chk = last_cap;
    run_to(5, 2'd3);
    run_to(6, 2'd3);
    ramp = last_cap;

    foreach (vt[i]) begin
      case (vt[i].fb)
        0: got = bars_a[vt[i].y * W + vt[i].x];
        1: got = bars_b[vt[i].y * W + vt[i].x];
        2: got = chk[vt[i].y * W + vt[i].x];
        default: got = ramp[vt[i].y * W + vt[i].x];
      endcase
      check($sformatf("pixel_vec%0d", i), 64'(got), 64'(vt[i].rgb));
    end

    run_to(7, 2'd0);
    run_to(8, 2'd0);
    check_frame(NPIX);
    check("underflow_clean", 64'(underflow_cnt), 64'(0));

    guard = 0;
    while (fr_len < (PV + BV + 10) * HT + PH + BH + 5 && guard < FT) begin
      sstep(2'd0); guard++;
    end
    drop_left = 10;
    run_to(9, 2'd0);
    check_frame(NPIX - 10);
    check("underflow_10", 64'(underflow_cnt), 64'(10));
    nmag = 0;
    foreach (last_cap[i]) if (last_cap[i] == 24'hFF00FF) nmag++;
    check("magenta_pixels", 64'(nmag), 64'(10));

    guard = 0;
    while (fr_len < 10 * HT + 40 && guard < FT) begin
      sstep(2'd0); guard++;
    end
    step(1'b1, 1'b1, 2'd0, 1'b1, sdat);
    check("rst_mid_idle", 64'({frame_start, hsync, vsync, de,
                               red, green, blue, underflow_cnt}), 64'(0));
    sstep(2'd0);
    check("rst_frame_start", 64'(frame_start), 64'(1));
    nf = nframes;
    run_to(nf + 1, 2'd0);
    check_frame(NPIX);

    e = 1'b1;
    s = 2'd1;
    for (int i = 0; i < 6000; i++) begin
      r = ($urandom % 2000) == 0;
      if ($urandom % 300 == 0) e = ~e;
      if ($urandom % 700 == 0) s = 2'($urandom);
      step(r, e, s, ($urandom % 4) != 0, 24'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
